// File: rtl/nios_lcd_sequencer.sv
// Avalon-MM slave that turns single-byte accesses into timed HD44780-style
// LCD bus cycles, optionally polling the busy flag after every write.
`timescale 1ns/1ps
module nios_lcd_sequencer #(
  parameter int unsigned SETUP_CYCLES  = 2,
  parameter int unsigned ENABLE_CYCLES = 12,
  parameter int unsigned HOLD_CYCLES   = 2,
  parameter bit          BUSY_POLL     = 1'b1,
  parameter int unsigned POLL_LIMIT    = 255
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] address,
  input  logic       read,
  input  logic       write,
  input  logic [7:0] writedata,
  output logic [7:0] readdata,
  output logic       waitrequest,
  output logic       timeout,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  inout  wire  [7:0] LCD_data
);

  typedef enum logic [2:0] {
    IDLE, SETUP, ENABLE, HOLD, POLL_SETUP, POLL_ENABLE, POLL_HOLD, DONE
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] cnt;
  logic [7:0] poll_cnt;
  logic [7:0] wdata_q;
  logic [7:0] capture_q;
  logic       rs_q, rw_q, is_write_q;
  logic       e_q, timeout_q;
  logic       req, last, capture_en;
  logic       rs, rw, drive;

  // Phase length minus one, so the counter reaches zero on a state's last cycle.
  function automatic logic [7:0] reload(input state_t s);
    case (s)
      SETUP, POLL_SETUP:   return 8'(SETUP_CYCLES - 1);
      ENABLE, POLL_ENABLE: return 8'(ENABLE_CYCLES - 1);
      HOLD, POLL_HOLD:     return 8'(HOLD_CYCLES - 1);
      default:             return 8'd0;
    endcase
  endfunction

  assign req         = read | write;
  assign last        = (cnt == 8'd0);
  assign waitrequest = req & (state != DONE);
  assign capture_en  = last & (((state == ENABLE) & rw_q) | (state == POLL_ENABLE));

  // NOTE: every always_comb output gets a default before the case so no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:        if (req)  state_nxt = SETUP;
      SETUP:       if (last) state_nxt = ENABLE;
      ENABLE:      if (last) state_nxt = HOLD;
      HOLD:        if (last) state_nxt = (is_write_q && BUSY_POLL) ? POLL_SETUP : DONE;
      POLL_SETUP:  if (last) state_nxt = POLL_ENABLE;
      POLL_ENABLE: if (last) state_nxt = POLL_HOLD;
      POLL_HOLD:   if (last) state_nxt = (capture_q[7] && (poll_cnt < 8'(POLL_LIMIT)))
                                         ? POLL_SETUP : DONE;
      DONE:        state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      e_q       <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state) cnt <= reload(state_nxt);
      else if (!last)         cnt <= cnt - 8'd1;
      // E comes straight from a flop so the strobe cannot glitch on decode.
      e_q       <= (state_nxt == ENABLE) || (state_nxt == POLL_ENABLE);
      timeout_q <= (state == POLL_HOLD) && (state_nxt == DONE) && capture_q[7] &&
                   (poll_cnt == 8'(POLL_LIMIT));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rs_q       <= 1'b0;
      rw_q       <= 1'b1;
      is_write_q <= 1'b0;
      wdata_q    <= 8'h00;
      capture_q  <= 8'h00;
      poll_cnt   <= 8'd0;
    end else begin
      if ((state == IDLE) && req) begin
        // Write wins over read, but RW still follows address bit 0.
        rs_q       <= address[1];
        rw_q       <= address[0];
        is_write_q <= write;
        wdata_q    <= writedata;
        poll_cnt   <= 8'd0;
      end
      if (capture_en) capture_q <= LCD_data;
      if ((state == POLL_ENABLE) && last) poll_cnt <= poll_cnt + 8'd1;
    end
  end

  always_comb begin
    rs    = 1'b0;
    rw    = 1'b1;
    drive = 1'b0;
    case (state)
      SETUP, ENABLE, HOLD: begin
        rs    = rs_q;
        rw    = rw_q;
        drive = ~rw_q;
      end
      default: ;
    endcase
  end

  assign LCD_E    = e_q;
  assign LCD_RS   = rs;
  assign LCD_RW   = rw;
  assign LCD_data = drive ? wdata_q : 8'hzz;
  assign readdata = capture_q;
  assign timeout  = timeout_q;

endmodule

// File: tb/tb_nios_lcd_sequencer.sv
// Scoreboard bench: one sequencer without busy polling, one polling with a
// short limit, each with its own behavioural LCD on the bidirectional bus.
`timescale 1ns/1ps
module tb_nios_lcd_sequencer;

  localparam int S_CYC   = 2;
  localparam int E_CYC   = 12;
  localparam int H_CYC   = 2;
  localparam int PHASE   = S_CYC + E_CYC + H_CYC;
  localparam int MAX_CYC = 1000;

  typedef struct {
    string      tag;
    logic [7:0] rdata;
    int         done_idx;
    int         pulses;
    int         touts;
    logic       rs;
    logic       rw;
    logic [7:0] wd;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] address;
  logic [7:0] writedata;
  logic       read_a, write_a, read_b, write_b;
  logic [7:0] readdata_a, readdata_b;
  logic       wait_a, wait_b, to_a, to_b;
  logic       e_a, e_b, rs_a, rs_b, rw_a, rw_b;
  wire  [7:0] lcd_data_a, lcd_data_b;

  logic [7:0] model_a;
  int         poll_total = 0;
  int         poll_base  = 0;
  int         busy_n     = 0;
  logic [7:0] model_b;
  logic       sel;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  nios_lcd_sequencer #(.BUSY_POLL(1'b0)) dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .read(read_a), .write(write_a),
    .writedata(writedata), .readdata(readdata_a), .waitrequest(wait_a), .timeout(to_a),
    .LCD_E(e_a), .LCD_RS(rs_a), .LCD_RW(rw_a), .LCD_data(lcd_data_a)
  );

  nios_lcd_sequencer #(.BUSY_POLL(1'b1), .POLL_LIMIT(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .address(address), .read(read_b), .write(write_b),
    .writedata(writedata), .readdata(readdata_b), .waitrequest(wait_b), .timeout(to_b),
    .LCD_E(e_b), .LCD_RS(rs_b), .LCD_RW(rw_b), .LCD_data(lcd_data_b)
  );

  // The LCD drives its bus only while E is high on a read cycle.
  assign lcd_data_a = (e_a && rw_a) ? model_a : 8'hzz;

  // Busy-flag model: status reads number 1..busy_n return busy, later ones ready.
  always @(posedge e_b) if (rw_b && !rs_b) poll_total++;
  assign model_b    = ((poll_total - poll_base) <= busy_n) ? 8'h80 : 8'h00;
  assign lcd_data_b = (e_b && rw_b) ? model_b : 8'hzz;

  wire       obs_e    = sel ? e_b        : e_a;
  wire       obs_rs   = sel ? rs_b       : rs_a;
  wire       obs_rw   = sel ? rw_b       : rw_a;
  wire       obs_wait = sel ? wait_b     : wait_a;
  wire       obs_to   = sel ? to_b       : to_a;
  wire [7:0] obs_rd   = sel ? readdata_b : readdata_a;
  wire [7:0] obs_data = sel ? lcd_data_b : lcd_data_a;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic drive_req(input logic d, input logic rd, input logic wr);
    if (d) begin read_b = rd; write_b = wr; end
    else   begin read_a = rd; write_a = wr; end
  endtask

  // Push the expected outcome, run the access, then pop and compare at DONE.
  task automatic xfer(input string tag, input logic d, input logic rd, input logic wr,
                      input logic [1:0] addr, input logic [7:0] wd, input int n_polls,
                      input logic [7:0] exp_rd, input int exp_to);
    exp_t       e, x;
    int         idx, rises, touts, bad, k, j;
    logic       prev_e, done, exp_e;
    logic [7:0] rd_done;
    e.tag      = tag;
    e.rdata    = exp_rd;
    e.done_idx = 1 + (1 + n_polls) * PHASE;
    e.pulses   = 1 + n_polls;
    e.touts    = exp_to;
    e.rs       = addr[1];
    e.rw       = addr[0];
    e.wd       = wd;
    sb.push_back(e);

    @(posedge clk); #1;
    sel       = d;
    address   = addr;
    writedata = wd;
    poll_base = poll_total;
    drive_req(d, rd, wr);

    idx = 0; rises = 0; touts = 0; bad = 0; prev_e = 1'b0; done = 1'b0; rd_done = 8'h00;
    while (!done && idx < MAX_CYC) begin
      @(negedge clk);
      if (idx == 0) check({tag, "_wait_comb"}, obs_wait, 1);
      if (obs_e && !prev_e) rises++;
      prev_e = obs_e;
      if (obs_to) touts++;
      if (!obs_wait) begin
        done    = 1'b1;
        rd_done = obs_rd;
      end else if (idx > 0) begin
        k     = (idx - 1) % PHASE;
        j     = (idx - 1) / PHASE;
        exp_e = (k >= S_CYC) && (k < S_CYC + E_CYC);
        if (obs_e !== exp_e) bad++;
        if (j == 0) begin
          if (obs_rs !== e.rs || obs_rw !== e.rw) bad++;
          if (!e.rw && obs_data !== e.wd) bad++;
        end else if (obs_rs !== 1'b0 || obs_rw !== 1'b1) bad++;
      end
      if (!done) idx++;
    end

    @(posedge clk); #1;
    drive_req(d, 1'b0, 1'b0);
    @(negedge clk);
    x = sb.pop_front();
    check({x.tag, "_done"},     done,    1);
    check({x.tag, "_done_idx"}, idx,     x.done_idx);
    check({x.tag, "_readdata"}, rd_done, x.rdata);
    check({x.tag, "_e_pulses"}, rises,   x.pulses);
    check({x.tag, "_timeouts"}, touts,   x.touts);
    check({x.tag, "_bus_trace"}, bad,    0);
    check({x.tag, "_idle_wait"}, obs_wait, 0);
    check({x.tag, "_rd_hold"},  obs_rd,  x.rdata);
    check({x.tag, "_to_low"},   obs_to,  0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset_n = 1'b0; address = 2'b00; writedata = 8'h00; sel = 1'b0;
    read_a = 1'b0; write_a = 1'b0; read_b = 1'b0; write_b = 1'b0;
    model_a = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_e",        e_a,        0);
    check("rst_rs",       rs_a,       0);
    check("rst_rw",       rw_a,       1);
    check("rst_readdata", readdata_a, 8'h00);
    check("rst_timeout",  to_b,       0);
    check("rst_wait",     wait_b,     0);
    @(negedge clk); reset_n = 1'b1;

    xfer("wr_41",   1'b0, 1'b0, 1'b1, 2'b10, 8'h41, 0, 8'h00, 0);
    model_a = 8'h5A;
    xfer("rd_5a",   1'b0, 1'b1, 1'b0, 2'b11, 8'hA5, 0, 8'h5A, 0);
    model_a = 8'hC3;
    xfer("rd_c3",   1'b0, 1'b1, 1'b0, 2'b01, 8'h3C, 0, 8'hC3, 0);

    busy_n = 3;
    xfer("poll_ok", 1'b1, 1'b0, 1'b1, 2'b00, 8'h01, 4, 8'h00, 0);
    busy_n = 255;
    xfer("poll_to", 1'b1, 1'b0, 1'b1, 2'b00, 8'h01, 4, 8'h80, 1);
    busy_n = 0;
    xfer("rw_both", 1'b1, 1'b1, 1'b1, 2'b00, 8'h33, 1, 8'h00, 0);

    // Reset while E is high must drop the strobe without waiting for a clock.
    @(posedge clk); #1;
    sel = 1'b0; address = 2'b10; writedata = 8'h55; write_a = 1'b1;
    n = 0;
    while (!e_a && n < 100) begin @(negedge clk); n++; end
    check("mid_e_seen", e_a, 1);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_e",        e_a,        0);
    check("mid_rst_rw",       rw_a,       1);
    check("mid_rst_rs",       rs_a,       0);
    check("mid_rst_readdata", readdata_a, 8'h00);
    check("mid_rst_wait",     wait_a,     1);
    write_a = 1'b0;
    #1;
    check("mid_rst_wait_rel", wait_a,     0);
    @(negedge clk); reset_n = 1'b1;

    xfer("wr_after", 1'b0, 1'b0, 1'b1, 2'b00, 8'h38, 0, 8'h00, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/nios_lcd_sequencer.md
NIOS_LCD_SEQUENCER -- requirements
Module: nios_lcd_sequencer

Interface
REQ-001 SHALL have parameter SETUP_CYCLES, default 2: cycles RS/RW/data are stable before E rises (range 1-255).
REQ-002 SHALL have parameter ENABLE_CYCLES, default 12: cycles E is held high (range 1-255).
REQ-003 SHALL have parameter HOLD_CYCLES, default 2: cycles RS/RW/data are held after E falls (range 1-255).
REQ-004 SHALL have parameter BUSY_POLL, default 1: when 1, each data or instruction write is followed by busy-flag polling.
REQ-005 SHALL have parameter POLL_LIMIT, default 255: maximum busy-flag reads per write (range 1-255).
REQ-006 SHALL have ports:
- clk  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  bit0 = RW, bit1 = RS of the LCD access.
- read  in  1  Avalon read request.
- write  in  1  Avalon write request.
- writedata  in  8  byte to LCD.
- readdata  out  8  byte captured from LCD.
- waitrequest  out  1  Avalon stall.
- timeout  out  1  one-cycle pulse when POLL_LIMIT is exhausted.
- LCD_E  out  1  LCD enable strobe.
- LCD_RS  out  1  LCD register select.
- LCD_RW  out  1  LCD read/not-write.
- LCD_data  inout  8  LCD bidirectional bus.

Function
REQ-007 SHALL implement states IDLE, SETUP, ENABLE, HOLD, POLL_SETUP, POLL_ENABLE, POLL_HOLD, DONE.
REQ-008 SHALL, in IDLE with read or write high, latch address, writedata and direction, then enter SETUP on the next edge.
REQ-009 SHALL give write priority over read when both are high; LCD_RW then follows address[0] unchanged.
REQ-010 SHALL define waitrequest = (read | write) & (state != DONE); it is combinational.
REQ-011 SHALL keep each state for the following counts, using an 8-bit down-counter reloaded on every state entry:
- SETUP / POLL_SETUP: SETUP_CYCLES cycles.
- ENABLE / POLL_ENABLE: ENABLE_CYCLES cycles.
- HOLD / POLL_HOLD: HOLD_CYCLES cycles.
REQ-012 SHALL drive LCD_E = 1 only in ENABLE and POLL_ENABLE, registered and glitch-free.
REQ-013 SHALL drive LCD_RS and LCD_RW from the latched address in SETUP, ENABLE and HOLD.
REQ-014 SHALL drive LCD_RS = 0 and LCD_RW = 1 in all POLL_* states.
REQ-015 SHALL drive LCD_data with the latched writedata only while LCD_RW = 0 in SETUP, ENABLE or HOLD; otherwise LCD_data is Z.
REQ-016 SHALL capture LCD_data into an internal register on the last ENABLE or POLL_ENABLE cycle of any read phase.
REQ-017 SHALL leave HOLD for:
- POLL_SETUP if the access was a write and BUSY_POLL = 1;
- DONE otherwise.
REQ-018 SHALL, on leaving POLL_HOLD, return to POLL_SETUP if captured bit7 = 1 and the poll count < POLL_LIMIT, else go to DONE.
REQ-019 SHALL pulse timeout for one cycle on DONE entry when bit7 = 1 and the poll count = POLL_LIMIT.
REQ-020 SHALL present the captured byte on readdata in DONE and hold it until the next capture.
REQ-021 SHALL, for a write with poll, present the final status byte on readdata.
REQ-022 SHALL stay in DONE exactly one cycle, then return to IDLE; a request still asserted there starts a new transfer.
REQ-023 SHALL make a non-polled transfer last 2+SETUP_CYCLES+ENABLE_CYCLES+HOLD_CYCLES cycles from the request cycle to the cycle with waitrequest low, inclusive (18 cycles at defaults).
REQ-024 SHALL reset the poll count to 0 on each new transfer.

Reset
REQ-025 SHALL, while reset_n = 0 and independent of clk, force:
- state IDLE, counters 0;
- LCD_E = 0, LCD_RS = 0, LCD_RW = 1, LCD_data Z;
- readdata = 0x00, timeout = 0.
REQ-026 SHALL, on reset mid-transfer, drop LCD_E immediately and abandon the transfer; waitrequest then follows REQ-010.

Verification
REQ-027 SHALL pass these directed scenarios at defaults:
- Write (BUSY_POLL = 0), address 2, writedata 0x41 -> RS = 1, RW = 0, data 0x41 for 2 cycles; E high for 12; hold 2; waitrequest low on cycle 17 after the request.
- Read, address 3, LCD model drives 0x5A -> readdata 0x5A in DONE; LCD_data never driven by the DUT.
- Write 0x01 with BUSY_POLL = 1; model returns 0x80 for 3 polls, then 0x00 -> four POLL_ENABLE pulses, readdata 0x00, timeout stays 0.
- Model holds 0x80 with POLL_LIMIT = 4 -> exactly 4 polls, timeout pulses once, transfer completes.
- read and write both high -> write performed, LCD_RW = 0.
- reset_n low during ENABLE -> LCD_E = 0 in the same cycle; after release, a new write completes normally.
